// File: rtl/pipeline_sink.sv
// Terminating sink for the stall-controlled pipeline: show-ahead FIFO plus stall back-pressure.
// Optional macro PIPE_SINK_OVF_CHECK_EN compiles in the sticky overflow flag and its assertion.
module pipeline_sink #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_done,
  input  logic                  in_co_filter,
  input  logic                  in_stall_d,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_done,
  output logic                  out_co_filter,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  drained,
  output logic                  overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [CW-1:0] StallCnt = CW'(DEPTH - 1);
  localparam logic [CW-1:0] OneCnt   = CW'(1);

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  done_mem [DEPTH];
  logic                  cof_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drained_q, drained_d;

  logic push_new;
  logic pop;
  logic full;
  logic push_ok;

  // A stalled stage re-presents its old word; only an unstalled valid word is new.
  assign push_new = in_valid && !in_stall_d;
  assign full     = (count_q == FullCnt);
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_new && (!full || pop);

  assign stall     = (count_q >= StallCnt);
  assign out_valid = (count_q != '0);

  always_comb begin
    out_data      = '0;
    out_done      = 1'b0;
    out_co_filter = 1'b0;
    if (out_valid) begin
      out_data      = data_mem[rd_ptr_q];
      out_done      = done_mem[rd_ptr_q];
      out_co_filter = cof_mem[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    drained_d = drained_q;
    if (push_ok) begin
      drained_d = 1'b0;
    end else if (pop && done_mem[rd_ptr_q] && (count_q == OneCnt)) begin
      drained_d = 1'b1;
    end
  end

  assign drained = drained_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drained_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drained_q <= drained_d;
    end
  end

  // Storage needs no reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr_q] <= in_data;
      done_mem[wr_ptr_q] <= in_done;
      cof_mem[wr_ptr_q]  <= in_co_filter;
    end
  end

`ifdef PIPE_SINK_OVF_CHECK_EN
  logic overflow_q;
  logic drop;

  assign drop = push_new && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

`ifndef SYNTHESIS
  ovf_check: assert property (@(posedge clk) disable iff (!rst) !drop);
`endif
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_sink.sv
// Scoreboard bench for pipeline_sink (DEPTH=4, DATA_WIDTH=8): directed vectors, queue-based monitor.
module tb_pipeline_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_done = 1'b0;
  logic       in_co_filter = 1'b0;
  logic       in_stall_d = 1'b0;
  logic       stall;
  logic [7:0] out_data;
  logic       out_done;
  logic       out_co_filter;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       drained;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  pipeline_sink #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_done      (in_done),
    .in_co_filter (in_co_filter),
    .in_stall_d   (in_stall_d),
    .stall        (stall),
    .out_data     (out_data),
    .out_done     (out_done),
    .out_co_filter(out_co_filter),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .drained      (drained),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a word presented with out_ready high is consumed at the coming edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {22'd0, out_done, out_co_filter, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("scoreboard_word", {22'd0, out_done, out_co_filter, out_data},
            {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one input vector; acc marks a word the sink is required to keep.
  task automatic drive(input logic v, input logic [7:0] d, input logic dn, input logic cf,
                       input logic sd, input logic rdy, input logic acc);
    in_valid     = v;
    in_data      = d;
    in_done      = dn;
    in_co_filter = cf;
    in_stall_d   = sd;
    out_ready    = rdy;
    if (acc) exp_q.push_back({dn, cf, d});
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    idle(1'b1);
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    step();
    chk({name, "_empty"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    logic [7:0] words [6];
    int         issued;
    logic       s;

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_drained", {31'd0, drained}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    step();
    step();
    rst = 1'b1;

    // Reset-then-stream: each word visible one cycle after its capture edge
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("stream_lat_11", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("stream_lat_22", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
    drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("stream_lat_33", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
    chk("stream_stall", {31'd0, stall}, 0);
    drain("stream");

    // Back-pressure through a stage register with registered stall echo
    words[0] = 8'hC0; words[1] = 8'hC1; words[2] = 8'hC2;
    words[3] = 8'hC3; words[4] = 8'hC4; words[5] = 8'hC5;
    issued = 0;
    idle(1'b0);
    for (int cyc = 0; cyc < 24; cyc++) begin
      out_ready = (cyc >= 9);
      if (cyc == 4) chk("bp_stall_at_3", {31'd0, stall}, 1);
      if (cyc == 8) begin
        chk("bp_stall_full", {31'd0, stall}, 1);
        chk("bp_overflow", {31'd0, overflow}, 0);
        chk("bp_queue_4", exp_q.size(), 4);
      end
      s = stall;
      step();
      in_stall_d = s;
      if (!s) begin
        if (issued < 6) begin
          in_valid = 1'b1;
          in_data  = words[issued];
          exp_q.push_back({2'b00, words[issued]});
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("bp_all_issued", issued, 6);
    drain("bp");

    // Held word: stalled stage must not be re-captured
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_no_capture", {31'd0, out_valid}, 0);
    end
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("held_captured", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
    drain("held");

    // Full, then simultaneous push/pop, then a push at full with no pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk("full_stall", {31'd0, stall}, 1);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("full_pp_stall", {31'd0, stall}, 1);
    chk("full_pp_head", {24'd0, out_data}, 32'hA2);
    chk("full_pp_overflow", {31'd0, overflow}, 0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_drop_head", {24'd0, out_data}, 32'hA2);
`ifdef PIPE_SINK_OVF_CHECK_EN
    chk("full_drop_overflow", {31'd0, overflow}, 1);
`else
    chk("full_drop_overflow", {31'd0, overflow}, 0);
`endif
    drain("full");
    chk("full_stall_low", {31'd0, stall}, 0);

    // Done drain
    drive(1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("done_present", {22'd0, out_valid, out_done, out_data}, {22'd0, 1'b1, 1'b1, 8'hAB});
    chk("done_not_yet", {31'd0, drained}, 0);
    idle(1'b1);
    step();
    chk("done_drained", {31'd0, drained}, 1);
    chk("done_out_valid", {31'd0, out_valid}, 0);
    drive(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("done_cleared", {31'd0, drained}, 0);
    drain("done");

    // Async reset mid-burst
    drive(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'hE2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'hE3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("burst_stall", {31'd0, stall}, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_out_bits", {22'd0, out_done, out_co_filter, out_data}, 0);
    chk("arst_stall", {31'd0, stall}, 0);
    chk("arst_drained", {31'd0, drained}, 0);
    chk("arst_overflow", {31'd0, overflow}, 0);
    idle(1'b1);
    step();
    rst = 1'b1;
    drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("post_rst_word", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h42});
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
